mem_stage_latch: RTL and testbench

- Memory stage plus M/W pipeline register of the 5-stage CPU.
- Consumes the X/M latch (instruction, ALU result, store data) and performs lw/sw against a variable-latency data memory using a req/ready handshake.
- Stalls upstream stages while an access is outstanding.
- Presents registered instruction, ALU result and memory read data to the writeback controller.

---
 rtl/mem_stage_latch.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_latch.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_latch.sv
// -----------------------------------------------------------------------------
// mem_stage_latch
//
// Memory stage plus M/W pipeline register of the 5-stage CPU. Takes the X/M
// latch contents, performs lw/sw against a variable-latency data memory over
// a req/ready handshake, stalls the upstream stages while an access is
// outstanding, and presents registered instruction / ALU result / load data
// to the writeback controller.
//
// Ports:
//   clock, reset          pipeline clock (rising edge), async active-low reset
//   xm_valid/insn/alu/
//   xm_storeData          X/M latch contents (insn, ALU result/address, rd value)
//   mem_stall             combinational: upstream holds X/M and PC while high
//   dmem_req/we/addr/
//   wdata                 registered request to data memory
//   dmem_ready/rdata      memory completion strobe and read data
//   mw_valid/insn/alu/
//   mw_dmem               M/W latch presented to writeback (bubble = all zero)
//   stall_count           saturating count of cycles with mem_stall high
// -----------------------------------------------------------------------------
module mem_stage_latch #(
    parameter int         ADDR_BITS = 12,
    parameter logic [4:0] LW_OPCODE = 5'b01000,
    parameter logic [4:0] SW_OPCODE = 5'b00111
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 xm_valid,
    input  logic [31:0]          xm_insn,
    input  logic [31:0]          xm_alu,
    input  logic [31:0]          xm_storeData,
    output logic                 mem_stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_BITS-1:0] dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ready,
    input  logic [31:0]          dmem_rdata,
    output logic                 mw_valid,
    output logic [31:0]          mw_insn,
    output logic [31:0]          mw_alu,
    output logic [31:0]          mw_dmem,
    output logic [15:0]          stall_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // Instruction and ALU result of the access in flight; X/M is not sampled
    // while BUSY, so these carry the instruction through to M/W.
    logic [31:0] hold_insn_reg;
    logic [31:0] hold_alu_reg;

    logic        xm_is_lw;
    logic        xm_is_sw;
    logic        memop;
    logic        hold_is_lw;
    logic        issue;
    logic        complete;

    assign xm_is_lw   = (xm_insn[31:27] == LW_OPCODE);
    assign xm_is_sw   = (xm_insn[31:27] == SW_OPCODE);
    assign memop      = xm_valid & (xm_is_lw | xm_is_sw);
    assign hold_is_lw = (hold_insn_reg[31:27] == LW_OPCODE);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; dmem_ready is ignored while IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (memop)      state_next = BUSY;
            BUSY:    if (dmem_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        mem_stall = 1'b0;
        issue     = 1'b0;
        complete  = 1'b0;
        case (state_reg)
            IDLE: begin
                mem_stall = memop;
                issue     = memop;
            end
            BUSY: begin
                // Stall is released in the completion cycle so upstream
                // advances on the same edge that retires the access.
                mem_stall = ~dmem_ready;
                complete  = dmem_ready;
            end
            default: ;
        endcase
    end

    // Memory request registers and holding registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            hold_insn_reg <= '0;
            hold_alu_reg  <= '0;
        end else if (issue) begin
            dmem_req      <= 1'b1;
            dmem_we       <= xm_is_sw;
            // Address bits above ADDR_BITS are intentionally discarded
            dmem_addr     <= xm_alu[ADDR_BITS-1:0];
            dmem_wdata    <= xm_storeData;
            hold_insn_reg <= xm_insn;
            hold_alu_reg  <= xm_alu;
        end else if (complete) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
        end
    end

    // M/W pipeline register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mw_valid <= 1'b0;
            mw_insn  <= '0;
            mw_alu   <= '0;
            mw_dmem  <= '0;
        end else if (complete) begin
            mw_valid <= 1'b1;
            mw_insn  <= hold_insn_reg;
            mw_alu   <= hold_alu_reg;
            mw_dmem  <= hold_is_lw ? dmem_rdata : 32'h0;
        end else if ((state_reg == IDLE) && !memop && xm_valid) begin
            mw_valid <= 1'b1;
            mw_insn  <= xm_insn;
            mw_alu   <= xm_alu;
            mw_dmem  <= 32'h0;
        end else begin
            // Bubble: insn 0 decodes as add $0,$0,$0, harmless at writeback
            mw_valid <= 1'b0;
            mw_insn  <= '0;
            mw_alu   <= '0;
            mw_dmem  <= '0;
        end
    end

    // Saturating stall counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (mem_stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_stage_latch.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_latch
//
// Scoreboard bench for mem_stage_latch. The driver issues instructions in
// program order and pushes the expected M/W result and the expected memory
// request into queues; a monitor pops M/W results, a memory responder pops
// requests and answers them with a per-request latency chosen by the driver.
// Load data comes from a reference memory updated in program order.
// -----------------------------------------------------------------------------
module tb_mem_stage_latch;

    localparam int         AB = 12;
    localparam logic [4:0] LW = 5'b01000;
    localparam logic [4:0] SW = 5'b00111;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          xm_valid = 1'b0;
    logic [31:0]   xm_insn = '0;
    logic [31:0]   xm_alu = '0;
    logic [31:0]   xm_storeData = '0;
    logic          mem_stall;
    logic          dmem_req;
    logic          dmem_we;
    logic [AB-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_ready;
    logic [31:0]   dmem_rdata = '0;
    logic          mw_valid;
    logic [31:0]   mw_insn;
    logic [31:0]   mw_alu;
    logic [31:0]   mw_dmem;
    logic [15:0]   stall_count;

    logic resp_ready = 1'b0;
    logic force_ready = 1'b0;
    assign dmem_ready = resp_ready | force_ready;

    always #5 clock = ~clock;

    mem_stage_latch #(
        .ADDR_BITS(AB),
        .LW_OPCODE(LW),
        .SW_OPCODE(SW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .xm_valid    (xm_valid),
        .xm_insn     (xm_insn),
        .xm_alu      (xm_alu),
        .xm_storeData(xm_storeData),
        .mem_stall   (mem_stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .mw_valid    (mw_valid),
        .mw_insn     (mw_insn),
        .mw_alu      (mw_alu),
        .mw_dmem     (mw_dmem),
        .stall_count (stall_count)
    );

    typedef struct {
        logic [31:0] insn;
        logic [31:0] alu;
        logic [31:0] dmem;
    } mw_t;

    typedef struct {
        logic          we;
        logic [AB-1:0] addr;
        logic [31:0]   wdata;
        int            lat;
    } req_t;

    mw_t         exp_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem[4096];
    logic [31:0] dev_mem[4096];
    int          checks = 0;
    int          errors = 0;
    int          exp_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: records what the instruction must produce at M/W and
    // at the memory port, and how many stall cycles it costs.
    task automatic expect_insn(input logic v, input logic [31:0] insn, input logic [31:0] alu,
                               input logic [31:0] sd, input int lat);
        logic [4:0] op;
        mw_t        e;
        req_t       r;
        op = insn[31:27];
        if (v && (op == LW || op == SW)) begin
            r.we    = (op == SW);
            r.addr  = alu[AB-1:0];
            r.wdata = sd;
            r.lat   = lat;
            req_q.push_back(r);
            e.insn = insn;
            e.alu  = alu;
            e.dmem = (op == LW) ? ref_mem[alu[AB-1:0]] : 32'h0;
            if (op == SW) ref_mem[alu[AB-1:0]] = sd;
            exp_q.push_back(e);
            exp_stall = exp_stall + 1 + lat;
            if (exp_stall > 65535) exp_stall = 65535;
        end else if (v) begin
            e.insn = insn;
            e.alu  = alu;
            e.dmem = 32'h0;
            exp_q.push_back(e);
        end
    endtask

    // Drive one instruction and hold it until upstream is allowed to advance.
    task automatic issue(input logic v, input logic [31:0] insn, input logic [31:0] alu,
                         input logic [31:0] sd, input int lat, input bit scramble,
                         input int bound, output int cycles);
        bit mop;
        mop = v && (insn[31:27] == LW || insn[31:27] == SW);
        expect_insn(v, insn, alu, sd, lat);
        xm_valid     = v;
        xm_insn      = insn;
        xm_alu       = alu;
        xm_storeData = sd;
        cycles = 0;
        forever begin
            @(negedge clock);
            if (!mem_stall) break;
            cycles++;
            if (cycles > bound) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: stalled %0d cycles, required release within %0d", cycles, bound);
                break;
            end
            @(posedge clock);
            #1;
            if (scramble) begin
                // X/M is not sampled while the access is in flight
                xm_valid     = 1'($urandom);
                xm_insn      = $urandom;
                xm_alu       = $urandom;
                xm_storeData = $urandom;
            end
        end
        @(posedge clock);
        #1;
        cycles++;
        chk("issue_latency", cycles, mop ? 32'(2 + lat) : 32'd1);
    endtask

    // Monitor: compare every valid M/W entry against the scoreboard
    initial begin
        mw_t e;
        forever begin
            @(negedge clock);
            if (mw_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mw_unexpected: got valid insn=%h, expected no entry", mw_insn);
                end else begin
                    e = exp_q.pop_front();
                    $display("mw   insn=%h alu=%h dmem=%h", mw_insn, mw_alu, mw_dmem);
                    chk("mw_insn", mw_insn, e.insn);
                    chk("mw_alu", mw_alu, e.alu);
                    chk("mw_dmem", mw_dmem, e.dmem);
                end
            end else begin
                chk("mw_bubble", mw_insn | mw_alu | mw_dmem, 32'h0);
            end
        end
    end

    // Memory responder: checks each request and answers after its latency
    initial begin
        bit   pending;
        int   wait_left;
        req_t cur;
        pending = 0;
        wait_left = 0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                pending = 0;
                resp_ready = 1'b0;
                continue;
            end
            if (resp_ready && pending) begin
                if (cur.we) dev_mem[cur.addr] = cur.wdata;
                pending = 0;
            end
            resp_ready = 1'b0;
            dmem_rdata = $urandom;
            if (dmem_req) begin
                if (!pending) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dmem_unexpected: got req addr=%h we=%b, expected none", dmem_addr, dmem_we);
                        cur.we = dmem_we;
                        cur.addr = dmem_addr;
                        cur.wdata = dmem_wdata;
                        cur.lat = 0;
                    end else begin
                        cur = req_q.pop_front();
                        $display("req  we=%b addr=%h wdata=%h lat=%0d", dmem_we, dmem_addr, dmem_wdata, cur.lat);
                        chk("req_we", 32'(dmem_we), 32'(cur.we));
                        chk("req_addr", 32'(dmem_addr), 32'(cur.addr));
                        chk("req_wdata", dmem_wdata, cur.wdata);
                    end
                    pending = 1;
                    wait_left = cur.lat;
                end else begin
                    chk("req_hold", {dmem_wdata[31:13], dmem_we, dmem_addr} ^ dmem_wdata,
                        {cur.wdata[31:13], cur.we, cur.addr} ^ cur.wdata);
                end
                if (wait_left == 0) begin
                    resp_ready = 1'b1;
                    dmem_rdata = cur.we ? $urandom : dev_mem[cur.addr];
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          k;
        int          lat;
        logic        v;
        logic [4:0]  op;
        logic [31:0] alu;
        logic [31:0] lw_insn;
        logic [31:0] sw_insn;

        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = $urandom;
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[12'h123] = 32'hDEAD_BEEF;
        dev_mem[12'h123] = 32'hDEAD_BEEF;
        lw_insn = {LW, 27'h0A5_1234};
        sw_insn = {SW, 27'h031_0042};

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_mw_valid", 32'(mw_valid), 32'd0);
        chk("rst_mw_insn", mw_insn, 32'd0);
        chk("rst_mw_alu", mw_alu, 32'd0);
        chk("rst_mw_dmem", mw_dmem, 32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);

        // Release with an add (insn 0) waiting in X/M
        xm_valid = 1'b1;
        xm_insn  = 32'h0;
        xm_alu   = 32'h0;
        expect_insn(1'b1, 32'h0, 32'h0, 32'h0, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("add_stall", 32'(mem_stall), 32'd0);
        chk("add_pre_valid", 32'(mw_valid), 32'd0);
        @(posedge clock);
        #1 xm_valid = 1'b0;
        @(negedge clock);
        chk("add_valid", 32'(mw_valid), 32'd1);
        chk("add_stall_count", 32'(stall_count), 32'd0);
        @(posedge clock);
        #1;

        // Directed lw, memory ready in the first request cycle
        expect_insn(1'b1, lw_insn, 32'h0000_0123, 32'h0, 0);
        xm_valid = 1'b1;
        xm_insn  = lw_insn;
        xm_alu   = 32'h0000_0123;
        @(negedge clock);
        chk("lw_c0_stall", 32'(mem_stall), 32'd1);
        chk("lw_c0_req", 32'(dmem_req), 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("lw_c1_req", 32'(dmem_req), 32'd1);
        chk("lw_c1_we", 32'(dmem_we), 32'd0);
        chk("lw_c1_addr", 32'(dmem_addr), 32'h123);
        chk("lw_c1_stall", 32'(mem_stall), 32'd0);
        @(posedge clock);
        #1 xm_valid = 1'b0;
        @(negedge clock);
        chk("lw_c2_valid", 32'(mw_valid), 32'd1);
        chk("lw_c2_insn", mw_insn, lw_insn);
        chk("lw_c2_dmem", mw_dmem, 32'hDEAD_BEEF);
        chk("lw_c2_req", 32'(dmem_req), 32'd0);
        chk("lw_stall_count", 32'(stall_count), 32'd1);
        @(posedge clock);
        #1;

        // Directed sw with three wait cycles: four stall cycles in total
        issue(1'b1, sw_insn, 32'hABCD_E456, 32'h0000_00AA, 3, 1'b0, 50, cyc);
        chk("sw_stall_count", 32'(stall_count), 32'd5);

        // Back-to-back loads with ready held high; the first reads the sw data
        issue(1'b1, lw_insn, 32'h0000_0456, 32'h0, 0, 1'b0, 50, cyc);
        issue(1'b1, lw_insn, 32'hFFFF_F123, 32'h0, 0, 1'b0, 50, cyc);
        chk("b2b_stall_count", 32'(stall_count), 32'd7);

        // Reset in the middle of an outstanding access
        expect_insn(1'b1, lw_insn, 32'h0000_0321, 32'h0, 20);
        xm_valid = 1'b1;
        xm_insn  = lw_insn;
        xm_alu   = 32'h0000_0321;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        chk("rst_busy_req", 32'(dmem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_req", 32'(dmem_req), 32'd0);
        chk("rst_async_we", 32'(dmem_we), 32'd0);
        chk("rst_async_mw_valid", 32'(mw_valid), 32'd0);
        chk("rst_async_count", 32'(stall_count), 32'd0);
        void'(exp_q.pop_back());
        exp_stall = 0;
        xm_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        force_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("idle_ready_req", 32'(dmem_req), 32'd0);
            chk("idle_ready_stall", 32'(mem_stall), 32'd0);
            chk("idle_ready_valid", 32'(mw_valid), 32'd0);
        end
        @(posedge clock);
        #1 force_ready = 1'b0;
        chk("idle_ready_count", 32'(stall_count), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            k   = $urandom_range(0, 9);
            lat = $urandom_range(0, 4);
            v   = 1'b1;
            if (k < 3) begin
                op = LW;
            end else if (k < 5) begin
                op = SW;
            end else begin
                op = 5'($urandom);
                while (op == LW || op == SW) op = 5'($urandom);
                if (k >= 8) begin
                    v = 1'b0;
                    if ($urandom_range(0, 1) == 1) op = LW;
                end
            end
            alu = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15));
            issue(v, {op, 27'($urandom)}, alu, $urandom, lat, 1'b1, 100, cyc);
        end
        xm_valid = 1'b0;
        chk("rand_stall_count", 32'(stall_count), 32'(exp_stall));

        // Long wait drives the stall counter into saturation
        issue(1'b1, lw_insn, 32'h0000_0777, 32'h0, 65600, 1'b0, 70000, cyc);
        chk("sat_stall_count", 32'(stall_count), 32'hFFFF);
        chk("sat_model_count", 32'(stall_count), 32'(exp_stall));
        issue(1'b1, lw_insn, 32'h0000_0123, 32'h0, 1, 1'b0, 50, cyc);
        issue(1'b1, 32'h0000_1111, 32'h0000_2222, 32'h0, 0, 1'b0, 50, cyc);
        xm_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("sat_hold", 32'(stall_count), 32'hFFFF);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        chk("request_drain", 32'(req_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
